// File: rtl/rom_qspi_pkg.sv
// Shared constants for the read-only Quad-SPI flash controller:
// FSM state encodings, transfer-size codes and default flash command bytes.
package rom_qspi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CMD   = 3'd1;
  localparam state_t ST_ADDR  = 3'd2;
  localparam state_t ST_MODE  = 3'd3;
  localparam state_t ST_DUMMY = 3'd4;
  localparam state_t ST_DATA  = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0]  DEF_CMD       = 8'hEB;
  localparam logic [7:0]  DEF_MODE_BYTE = 8'h00;
  localparam int unsigned DEF_DUMMY_SCK = 4;

  // Number of SCK cycles in the data phase: two nibbles per byte.
  function automatic logic [3:0] data_sck(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 4'd2;
      SZ_HALF: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/rom_qspi_ctrl.sv
// Quad-SPI flash read controller: one 0xEB Fast Read Quad I/O transaction per
// bus read request, returning little-endian data zero-extended to 32 bits.
module rom_qspi_ctrl
  import rom_qspi_pkg::*;
#(
  parameter logic [7:0]  CMD       = DEF_CMD,
  parameter logic [7:0]  MODE_BYTE = DEF_MODE_BYTE,
  parameter int unsigned DUMMY_SCK = DEF_DUMMY_SCK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] baddr,
  input  logic [1:0]  bsz,
  input  logic        trigger_rd,
  output logic [31:0] bdo,
  output logic        brdy,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  io_o,
  output logic [3:0]  io_oe,
  input  logic [3:0]  io_i
);

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_SCK - 1);

  state_t      state;
  logic        phase;    // 0 = SCK low (launch), 1 = SCK high
  logic [3:0]  cnt;      // SCK cycles completed in the current state
  logic [31:0] sreg;     // outgoing opcode/address/mode, MSB first
  logic [31:0] dat;      // data assembly; copied to bdo only on DONE entry
  logic [1:0]  sz;
  logic [4:0]  nib_lsb;

  // Nibble k lands in byte k/2, high half first.
  assign nib_lsb = {cnt[2:1], ~cnt[0], 2'b00};
  assign sck     = phase;

  // NOTE: io_o/io_oe are decoded from registered state only, so they change at
  // the launch edge together with sck falling and need no reset of their own.
  always_comb begin
    io_o  = 4'h0;
    io_oe = 4'h0;
    case (state)
      ST_CMD: begin
        io_o  = {3'b000, sreg[31]};
        io_oe = 4'b0001;
      end
      ST_ADDR, ST_MODE: begin
        io_o  = sreg[31:28];
        io_oe = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      phase <= 1'b0;
      cnt   <= '0;
      sreg  <= '0;
      dat   <= '0;
      sz    <= SZ_BYTE;
      ce_n  <= 1'b1;
      brdy  <= 1'b0;
      bdo   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger_rd) begin
            state <= ST_CMD;
            ce_n  <= 1'b0;
            sz    <= bsz;
            sreg  <= {CMD, baddr};
            dat   <= '0;
            cnt   <= '0;
            phase <= 1'b0;
          end
        end

        ST_CMD: begin
          phase <= ~phase;
          if (phase) begin
            sreg <= {sreg[30:0], 1'b0};
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              state <= ST_ADDR;
              cnt   <= '0;
            end
          end
        end

        ST_ADDR: begin
          phase <= ~phase;
          if (phase) begin
            sreg <= {sreg[27:0], 4'h0};
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd5) begin
              state <= ST_MODE;
              cnt   <= '0;
              sreg  <= {MODE_BYTE, 24'h0};
            end
          end
        end

        ST_MODE: begin
          phase <= ~phase;
          if (phase) begin
            sreg <= {sreg[27:0], 4'h0};
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd1) begin
              state <= ST_DUMMY;
              cnt   <= '0;
            end
          end
        end

        ST_DUMMY: begin
          phase <= ~phase;
          if (phase) begin
            cnt <= cnt + 4'd1;
            if (cnt == DUMMY_LAST) begin
              state <= ST_DATA;
              cnt   <= '0;
            end
          end
        end

        ST_DATA: begin
          // One trailing low-phase cycle after the last sample, then hand off.
          if (!phase && cnt == data_sck(sz)) begin
            state <= ST_DONE;
            ce_n  <= 1'b1;
            brdy  <= 1'b1;
            bdo   <= dat;
          end else begin
            phase <= ~phase;
            if (phase) begin
              dat[nib_lsb +: 4] <= io_i;
              cnt               <= cnt + 4'd1;
            end
          end
        end

        ST_DONE: begin
          if (!trigger_rd) begin
            state <= ST_IDLE;
            brdy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          phase <= 1'b0;
          ce_n  <= 1'b1;
          brdy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_qspi_ctrl.sv
// Directed bench for rom_qspi_ctrl with a behavioural 0xEB flash model that
// returns byte[a] = a[7:0] ^ 8'h5A.
module tb_rom_qspi_ctrl;
  import rom_qspi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] baddr;
  logic [1:0]  bsz;
  logic        trigger_rd;
  logic [31:0] bdo;
  logic        brdy;
  logic        sck;
  logic        ce_n;
  logic [3:0]  io_o;
  logic [3:0]  io_oe;
  logic [3:0]  io_i = 4'h0;

  int total = 0;
  int bad   = 0;

  rom_qspi_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .baddr      (baddr),
    .bsz        (bsz),
    .trigger_rd (trigger_rd),
    .bdo        (bdo),
    .brdy       (brdy),
    .sck        (sck),
    .ce_n       (ce_n),
    .io_o       (io_o),
    .io_oe      (io_oe),
    .io_i       (io_i)
  );

  always #5 clk = ~clk;

  // ---------------- flash model ----------------
  int          m_k      = 0;   // rising SCK edges in the current select
  int          idle_sck = 0;   // rising SCK edges seen while deselected
  int          oe_bad   = 0;
  int          pulses   = 0;
  logic [7:0]  m_cmd    = 8'h00;
  logic [23:0] m_addr   = 24'h0;
  logic [7:0]  m_mode   = 8'hFF;

  always @(negedge ce_n) pulses++;

  always @(posedge sck or posedge ce_n) begin
    if (ce_n) begin
      if (sck) idle_sck++;
      m_k = 0;
    end else begin
      m_k++;
      if (m_k <= 8) begin
        m_cmd = {m_cmd[6:0], io_o[0]};
        if (io_oe !== 4'b0001) oe_bad++;
      end else if (m_k <= 14) begin
        m_addr = {m_addr[19:0], io_o};
        if (io_oe !== 4'b1111) oe_bad++;
      end else if (m_k <= 16) begin
        m_mode = {m_mode[3:0], io_o};
        if (io_oe !== 4'b1111) oe_bad++;
      end else if (io_oe !== 4'b0000) begin
        oe_bad++;
      end
    end
  end

  // Flash launches data on the falling edge after the last dummy cycle.
  always @(negedge sck) begin
    if (!ce_n && m_k >= 20) begin
      int          j;
      logic [23:0] a;
      logic [7:0]  b;
      j = m_k - 20;
      a = m_addr + 24'(j / 2);
      b = a[7:0] ^ 8'h5A;
      io_i = (j % 2 == 0) ? b[7:4] : b[3:0];
    end
  end

  // ---------------- stimulus helper (no checking) ----------------
  task automatic run_read(input logic [23:0] a, input logic [1:0] s, input int hold,
                          output int lat, output logic [31:0] data, output int brdy_cyc,
                          output int npulse, output int bdo_chg);
    int          p0;
    bit          done;
    logic [31:0] prev;
    p0 = pulses; lat = -1; data = '0; brdy_cyc = 0; bdo_chg = 0; done = 1'b0;
    @(negedge clk);
    prev = bdo;
    baddr = a; bsz = s; trigger_rd = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk); #1;
      if (brdy) begin
        if (lat < 0) begin lat = n; data = bdo; end
        brdy_cyc++;
      end else if (lat >= 0) begin
        done = 1'b1;
      end else if (bdo !== prev) begin
        bdo_chg++;
      end
      if (n + 1 >= hold) trigger_rd = 1'b0;
    end
    trigger_rd = 1'b0;
    repeat (4) @(posedge clk);
    #1 npulse = pulses - p0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; trigger_rd = 1'b0; baddr = '0; bsz = SZ_BYTE;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ce_n !== 1'b1)   begin bad++; $display("FAIL reset_ce_n: got %b want 1", ce_n); end
    total++; if (sck !== 1'b0)    begin bad++; $display("FAIL reset_sck: got %b want 0", sck); end
    total++; if (brdy !== 1'b0)   begin bad++; $display("FAIL reset_brdy: got %b want 0", brdy); end
    total++; if (bdo !== 32'h0)   begin bad++; $display("FAIL reset_bdo: got %h want 00000000", bdo); end
    total++; if (io_oe !== 4'h0)  begin bad++; $display("FAIL reset_io_oe: got %b want 0000", io_oe); end
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (idle_sck !== 0)  begin bad++; $display("FAIL idle_sck_edges: got %0d want 0", idle_sck); end
    total++; if (pulses !== 0)    begin bad++; $display("FAIL idle_ce_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_byte_read();
    int lat, bc, np, chg, oe0;
    logic [31:0] d;
    oe0 = oe_bad;
    run_read(24'h000003, SZ_BYTE, 120, lat, d, bc, np, chg);
    total++; if (lat !== 45)          begin bad++; $display("FAIL byte_latency: got %0d want 45", lat); end
    total++; if (d !== 32'h00000059)  begin bad++; $display("FAIL byte_data: got %h want 00000059", d); end
    total++; if (bc !== 75)           begin bad++; $display("FAIL byte_brdy_hold: got %0d want 75", bc); end
    total++; if (np !== 1)            begin bad++; $display("FAIL byte_ce_pulses: got %0d want 1", np); end
    total++; if (m_cmd !== 8'hEB)     begin bad++; $display("FAIL byte_opcode: got %h want eb", m_cmd); end
    total++; if (m_addr !== 24'h3)    begin bad++; $display("FAIL byte_addr: got %h want 000003", m_addr); end
    total++; if (m_mode !== 8'h00)    begin bad++; $display("FAIL byte_mode: got %h want 00", m_mode); end
    total++; if (oe_bad - oe0 !== 0)  begin bad++; $display("FAIL byte_io_oe: got %0d bad edges want 0", oe_bad - oe0); end
    total++; if (bdo !== 32'h00000059) begin bad++; $display("FAIL byte_bdo_held: got %h want 00000059", bdo); end
    total++; if (idle_sck !== 0)      begin bad++; $display("FAIL byte_idle_sck: got %0d want 0", idle_sck); end
  endtask

  task automatic test_half_read();
    int lat, bc, np, chg, oe0;
    logic [31:0] d;
    oe0 = oe_bad;
    run_read(24'h000002, SZ_HALF, 60, lat, d, bc, np, chg);
    total++; if (lat !== 49)          begin bad++; $display("FAIL half_latency: got %0d want 49", lat); end
    total++; if (d !== 32'h00005958)  begin bad++; $display("FAIL half_data: got %h want 00005958", d); end
    total++; if (m_addr !== 24'h2)    begin bad++; $display("FAIL half_addr: got %h want 000002", m_addr); end
    total++; if (np !== 1)            begin bad++; $display("FAIL half_ce_pulses: got %0d want 1", np); end
    total++; if (oe_bad - oe0 !== 0)  begin bad++; $display("FAIL half_io_oe: got %0d bad edges want 0", oe_bad - oe0); end
  endtask

  task automatic test_word_read();
    int lat, bc, np, chg, oe0;
    logic [31:0] d;
    oe0 = oe_bad;
    run_read(24'h000004, SZ_WORD, 70, lat, d, bc, np, chg);
    total++; if (lat !== 57)          begin bad++; $display("FAIL word_latency: got %0d want 57", lat); end
    total++; if (d !== 32'h5D5C5F5E)  begin bad++; $display("FAIL word_data: got %h want 5d5c5f5e", d); end
    total++; if (m_addr !== 24'h4)    begin bad++; $display("FAIL word_addr: got %h want 000004", m_addr); end
    total++; if (np !== 1)            begin bad++; $display("FAIL word_ce_pulses: got %0d want 1", np); end
    total++; if (chg !== 0)           begin bad++; $display("FAIL word_bdo_early: got %0d changes want 0", chg); end
    total++; if (oe_bad - oe0 !== 0)  begin bad++; $display("FAIL word_io_oe: got %0d bad edges want 0", oe_bad - oe0); end
  endtask

  task automatic test_pulse_trigger();
    int lat, bc, np, chg;
    logic [31:0] d;
    run_read(24'h000007, SZ_BYTE, 1, lat, d, bc, np, chg);
    total++; if (lat !== 45)          begin bad++; $display("FAIL pulse_latency: got %0d want 45", lat); end
    total++; if (d !== 32'h0000005D)  begin bad++; $display("FAIL pulse_data: got %h want 0000005d", d); end
    total++; if (bc !== 1)            begin bad++; $display("FAIL pulse_brdy_len: got %0d want 1", bc); end
    total++; if (np !== 1)            begin bad++; $display("FAIL pulse_ce_pulses: got %0d want 1", np); end
  endtask

  task automatic test_reset_mid_addr();
    int lat, bc, np, chg;
    logic [31:0] d;
    @(negedge clk);
    baddr = 24'hABCDEF; bsz = SZ_WORD; trigger_rd = 1'b1;
    repeat (21) @(posedge clk);   // edges t0..t0+20: third address SCK
    #1;
    total++; if (io_oe !== 4'b1111)  begin bad++; $display("FAIL abort_in_addr: got io_oe %b want 1111", io_oe); end
    #2 rst = 1'b1;
    #1;
    total++; if (ce_n !== 1'b1)      begin bad++; $display("FAIL abort_ce_n: got %b want 1", ce_n); end
    total++; if (sck !== 1'b0)       begin bad++; $display("FAIL abort_sck: got %b want 0", sck); end
    total++; if (io_oe !== 4'h0)     begin bad++; $display("FAIL abort_io_oe: got %b want 0000", io_oe); end
    total++; if (io_o !== 4'h0)      begin bad++; $display("FAIL abort_io_o: got %h want 0", io_o); end
    total++; if (brdy !== 1'b0)      begin bad++; $display("FAIL abort_brdy: got %b want 0", brdy); end
    total++; if (bdo !== 32'h0)      begin bad++; $display("FAIL abort_bdo: got %h want 00000000", bdo); end
    trigger_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_read(24'h000003, SZ_BYTE, 1, lat, d, bc, np, chg);
    total++; if (lat !== 45)         begin bad++; $display("FAIL after_abort_latency: got %0d want 45", lat); end
    total++; if (d !== 32'h00000059) begin bad++; $display("FAIL after_abort_data: got %h want 00000059", d); end
    total++; if (np !== 1)           begin bad++; $display("FAIL after_abort_ce_pulses: got %0d want 1", np); end
  endtask

  initial begin
    test_reset();
    test_byte_read();
    test_half_read();
    test_word_read();
    test_pulse_trigger();
    test_reset_mid_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/rom_qspi_ctrl.md
# rom_qspi_ctrl

Read-only Quad-SPI (QSPI) flash controller. It turns a single bus read request (address and size) into one Fast Read Quad I/O (0xEB) transaction on an external serial flash, and returns the assembled little-endian data word. It sits between the CPU instruction/data bus and the board's boot/program flash. Pad tristating stays outside the block.

## Interface
- CMD, 8'hEB — quad I/O read opcode, sent on io0 only.
- MODE_BYTE, 8'h00 — mode bits sent after the address; non-continuous mode.
- DUMMY_SCK, 4 — dummy SCK cycles after the mode byte.
- clk  in  1  — single system clock.
- rst  in  1  — reset, asynchronous, active-high.
- baddr  in  24  — byte address into flash; sampled at transaction start.
- bsz  in  2  — transfer size, sampled at start: 0 = byte, 1 = halfword, 2 or 3 = word.
- trigger_rd  in  1  — level read request.
- bdo  out  32  — read data, zero-extended; byte at baddr in [7:0], baddr+1 in [15:8], and so on.
- brdy  out  1  — data valid / transaction done.
- sck  out  1  — flash clock, clk/2, SPI mode 0, idles low.
- ce_n  out  1  — flash chip select, active low.
- io_o  out  4  — flash data out.
- io_oe  out  4  — per-line output enable.
- io_i  in  4  — flash data in.

## Operation
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE.
- IDLE → CMD when trigger_rd = 1.
  - In that cycle, latch baddr and bsz, and drive ce_n low.
- CMD: 8 SCK cycles, CMD sent MSB first on io0. io_oe = 4'b0001.
- ADDR: 6 SCK cycles, baddr sent one nibble per SCK, MSB nibble first. io_oe = 4'b1111.
- MODE: 2 SCK cycles, MODE_BYTE, high nibble first. io_oe = 4'b1111.
- DUMMY: DUMMY_SCK cycles. io_oe = 0.
- DATA: N SCK cycles, N = 2 / 4 / 8 for byte / half / word. io_oe = 0.
  - Per byte, the first nibble received is bits [7:4] and the second is bits [3:0].
  - Bytes fill bdo from [7:0] upward.
  - Unused upper bytes are 0.
- DONE: ce_n high, sck low, brdy = 1, bdo held stable.
  - Stay in DONE while trigger_rd = 1.
  - Go to IDLE on the first cycle trigger_rd = 0.
  - Result: exactly one flash read per trigger assertion, even if trigger_rd is held high for a long time.
- trigger_rd dropping during CMD..DATA is ignored. The transaction completes, brdy is high for one cycle in DONE, then the block returns to IDLE.
- A new trigger is honoured only from IDLE. The next read can start on the cycle after DONE exits.
- Reset (asynchronous, at any time) aborts immediately:
  - state = IDLE, ce_n = 1, sck = 0, io_oe = 0, io_o = 0, brdy = 0, bdo = 0.

## Timing
- SCK period is 2 clk.
  - On the first clk of each SCK cycle, sck = 0 and the controller drives io_o (launch).
  - On the second clk, sck = 1. io_i is sampled at the clk edge that ends the high phase.
- Trigger sampled at edge t0:
  - ce_n falls after t0.
  - Total SCK cycles S = 20 + N with default parameters (8 + 6 + 2 + 4 + N).
  - brdy rises after edge t0 + 2·S + 1.
  - Byte read: brdy after t0 + 45. Half: t0 + 49. Word: t0 + 57.
- ce_n is deasserted in the same cycle brdy rises, giving a minimum ce_n-high time of 1 clk plus the time until the next trigger.
- bdo changes only on entry to DONE; it is never visible partially assembled.

## Structure
- Package rom_qspi_pkg holds:
  - the state enum;
  - the bsz encodings (SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2);
  - the default CMD and MODE_BYTE constants.
- A single module contains:
  - one SCK-cycle counter;
  - the phase toggle;
  - the shift-out register (opcode/address/mode);
  - the data assembly register.
- No sub-module is needed. The pad tristate (io_o / io_oe / io_i → inout) lives in the top level.

## Test plan
The bench uses a QSPI flash model that answers 0xEB with byte[a] = a[7:0] ^ 8'h5A.
- Reset held for 2 cycles: ce_n = 1, sck = 0, brdy = 0, bdo = 0, io_oe = 0. No sck edges while idle.
- Byte read:
  - Stimulus: baddr = 3, bsz = 0, trigger_rd high for 120 cycles.
  - Response: io0 carries 0xEB; address nibbles 0,0,0,0,0,3; brdy at t0 + 45; bdo = 0x00000059; exactly one ce_n low pulse; brdy stays 1 until trigger_rd falls, then 0 the next cycle.
- Half read: baddr = 2, bsz = 1 → bdo = 0x00005958, brdy at t0 + 49.
- Word read: baddr = 4, bsz = 2 → bdo = 0x5D5C5F5E, brdy at t0 + 57.
- Trigger pulsed high for a single cycle (baddr = 7, bsz = 0) → transaction completes, bdo = 0x0000005D, brdy high for exactly 1 cycle.
- Reset asserted mid-ADDR → ce_n = 1 and all outputs at reset values immediately. A following byte read at baddr = 3 returns 0x00000059.
